// File: rtl/iq_select_broadcast.sv
// Issue-queue select and result-tag broadcast: picks one ready entry per port,
// registers the grants, and replays each destination tag after its FU latency.
module iq_select_broadcast #(
  parameter int IQ_ENT_NUM  = 16,
  parameter int IQ_ENT_SEL  = 4,
  parameter int PHY_REG_SEL = 6,
  parameter int MAX_LATENCY = 4,
  parameter int LAT_W       = 3
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [IQ_ENT_NUM-1:0]             request,
  input  logic [IQ_ENT_NUM-1:0]             port_sel,
  input  logic [IQ_ENT_NUM-1:0]             writes_dst,
  input  logic [IQ_ENT_NUM*PHY_REG_SEL-1:0] dst_flat,
  input  logic [IQ_ENT_NUM*LAT_W-1:0]       lat_flat,
  input  logic                              fu_busy_0,
  input  logic                              fu_busy_1,
  input  logic                              prmiss,
  output logic                              grant_valid_0,
  output logic [IQ_ENT_SEL-1:0]             grant_idx_0,
  output logic                              grant_valid_1,
  output logic [IQ_ENT_SEL-1:0]             grant_idx_1,
  output logic                              bcast_valid_1,
  output logic [PHY_REG_SEL-1:0]            broadcast_tag1,
  output logic                              bcast_valid_2,
  output logic [PHY_REG_SEL-1:0]            broadcast_tag2
);

  logic [IQ_ENT_NUM-1:0]                            mask_q, mask_d;
  logic [1:0][MAX_LATENCY-1:0]                      slot_v_q, slot_v_d;
  logic [1:0][MAX_LATENCY-1:0][PHY_REG_SEL-1:0]     slot_tag_q, slot_tag_d;
  logic [1:0]                                       grant_valid_q, grant_valid_d;
  logic [1:0][IQ_ENT_SEL-1:0]                       grant_idx_q, grant_idx_d;

  logic [1:0]                 found;
  logic [1:0][IQ_ENT_SEL-1:0] sel_idx;
  logic [LAT_W-1:0]           ent_lat;
  logic [LAT_W-1:0]           sel_lat;
  logic                       occupied;
  logic                       port_busy;
  logic                       lat_bad;

  always_comb begin
    // Every slot moves one step closer to broadcast; invalid slots carry tag 0.
    slot_v_d      = '0;
    slot_tag_d    = '0;
    grant_valid_d = '0;
    grant_idx_d   = '0;
    mask_d        = '0;
    found         = '0;
    sel_idx       = '0;
    ent_lat       = '0;
    sel_lat       = '0;
    occupied      = 1'b0;
    port_busy     = 1'b0;
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < MAX_LATENCY - 1; k++) begin
        slot_v_d[p][k]   = slot_v_q[p][k+1];
        slot_tag_d[p][k] = slot_tag_q[p][k+1];
      end
    end

    for (int p = 0; p < 2; p++) begin
      port_busy = (p == 0) ? fu_busy_0 : fu_busy_1;
      for (int i = 0; i < IQ_ENT_NUM; i++) begin
        ent_lat  = lat_flat[i*LAT_W +: LAT_W];
        // s[L] shifts into s[L-1] this edge; at L == MAX_LATENCY nothing matches.
        occupied = 1'b0;
        for (int k = 0; k < MAX_LATENCY; k++) begin
          if (ent_lat == LAT_W'(k)) occupied = slot_v_q[p][k];
        end
        if (!found[p] && request[i] && (port_sel[i] == 1'(p)) && !mask_q[i] &&
            !(writes_dst[i] && occupied) && !port_busy && !prmiss) begin
          found[p]   = 1'b1;
          sel_idx[p] = IQ_ENT_SEL'(i);
        end
      end

      if (found[p]) begin
        grant_valid_d[p]    = 1'b1;
        grant_idx_d[p]      = sel_idx[p];
        mask_d[sel_idx[p]]  = 1'b1;
        sel_lat = lat_flat[sel_idx[p]*LAT_W +: LAT_W];
        if (writes_dst[sel_idx[p]]) begin
          for (int k = 0; k < MAX_LATENCY; k++) begin
            if (sel_lat == LAT_W'(k + 1)) begin
              slot_v_d[p][k]   = 1'b1;
              slot_tag_d[p][k] = dst_flat[sel_idx[p]*PHY_REG_SEL +: PHY_REG_SEL];
            end
          end
        end
      end
    end

    if (prmiss) begin
      slot_v_d      = '0;
      slot_tag_d    = '0;
      grant_valid_d = '0;
      grant_idx_d   = '0;
      mask_d        = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q        <= '0;
      slot_v_q      <= '0;
      slot_tag_q    <= '0;
      grant_valid_q <= '0;
      grant_idx_q   <= '0;
    end else begin
      mask_q        <= mask_d;
      slot_v_q      <= slot_v_d;
      slot_tag_q    <= slot_tag_d;
      grant_valid_q <= grant_valid_d;
      grant_idx_q   <= grant_idx_d;
    end
  end

  assign grant_valid_0  = grant_valid_q[0];
  assign grant_idx_0    = grant_idx_q[0];
  assign grant_valid_1  = grant_valid_q[1];
  assign grant_idx_1    = grant_idx_q[1];
  assign bcast_valid_1  = slot_v_q[0][0];
  assign broadcast_tag1 = slot_tag_q[0][0];
  assign bcast_valid_2  = slot_v_q[1][0];
  assign broadcast_tag2 = slot_tag_q[1][0];

  // A requesting entry must carry a latency in 1..MAX_LATENCY.
  always_comb begin
    lat_bad = 1'b0;
    for (int i = 0; i < IQ_ENT_NUM; i++) begin
      if (request[i] && ((lat_flat[i*LAT_W +: LAT_W] == '0) ||
                         (lat_flat[i*LAT_W +: LAT_W] > LAT_W'(MAX_LATENCY))))
        lat_bad = 1'b1;
    end
  end

  a_legal_latency: assert property (@(posedge clk) disable iff (reset) !lat_bad);

endmodule

// File: tb/tb_iq_select_broadcast.sv
// Bench for iq_select_broadcast: directed scenarios plus a randomized run
// checked against a booking-calendar model of the select/broadcast rules.
module tb_iq_select_broadcast;
  localparam int N   = 16;
  localparam int SEL = 4;
  localparam int PW  = 6;
  localparam int ML  = 4;
  localparam int LW  = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    request, port_sel, writes_dst;
  logic [N*PW-1:0] dst_flat;
  logic [N*LW-1:0] lat_flat;
  logic            fu_busy_0, fu_busy_1, prmiss;
  logic            grant_valid_0, grant_valid_1, bcast_valid_1, bcast_valid_2;
  logic [SEL-1:0]  grant_idx_0, grant_idx_1;
  logic [PW-1:0]   broadcast_tag1, broadcast_tag2;

  iq_select_broadcast dut (
    .clk(clk), .reset(reset), .request(request), .port_sel(port_sel),
    .writes_dst(writes_dst), .dst_flat(dst_flat), .lat_flat(lat_flat),
    .fu_busy_0(fu_busy_0), .fu_busy_1(fu_busy_1), .prmiss(prmiss),
    .grant_valid_0(grant_valid_0), .grant_idx_0(grant_idx_0),
    .grant_valid_1(grant_valid_1), .grant_idx_1(grant_idx_1),
    .bcast_valid_1(bcast_valid_1), .broadcast_tag1(broadcast_tag1),
    .bcast_valid_2(bcast_valid_2), .broadcast_tag2(broadcast_tag2)
  );

  always #5 clk = ~clk;

  logic [4:0] g0, g1;
  logic [6:0] b1, b2;
  assign g0 = {grant_valid_0, grant_idx_0};
  assign g1 = {grant_valid_1, grant_idx_1};
  assign b1 = {bcast_valid_1, broadcast_tag1};
  assign b2 = {bcast_valid_2, broadcast_tag2};

  int errors = 0;
  int checks = 0;

  // Model: a calendar of booked broadcast cycles per port, plus the set of
  // entries granted in the previous cycle.
  int            cyc = 0;
  bit            bk_v [2][64];
  bit [PW-1:0]   bk_tag [2][64];
  bit [N-1:0]    m_last;
  bit            m_gv [2];
  bit [SEL-1:0]  m_gi [2];

  task automatic model_step();
    bit [N-1:0] granted;
    bit         hit;
    bit         busy;
    int         l;
    int         slot;
    granted = '0;
    if (reset) begin
      for (int p = 0; p < 2; p++) begin
        m_gv[p] = 1'b0;
        m_gi[p] = '0;
        for (int c = 0; c < 64; c++) begin
          bk_v[p][c]   = 1'b0;
          bk_tag[p][c] = '0;
        end
      end
      m_last = '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        m_gv[p] = 1'b0;
        m_gi[p] = '0;
        busy = (p == 0) ? fu_busy_0 : fu_busy_1;
        hit  = 1'b0;
        if (!busy && !prmiss) begin
          for (int i = 0; i < N; i++) begin
            l    = int'(lat_flat[i*LW +: LW]);
            slot = (cyc + l) % 64;
            if (!hit && request[i] && (port_sel[i] == (p == 1)) && !m_last[i] &&
                (!writes_dst[i] || !bk_v[p][slot])) begin
              hit = 1'b1;
              m_gv[p] = 1'b1;
              m_gi[p] = SEL'(i);
              granted[i] = 1'b1;
              if (writes_dst[i]) begin
                bk_v[p][slot]   = 1'b1;
                bk_tag[p][slot] = dst_flat[i*PW +: PW];
              end
            end
          end
        end
      end
      if (prmiss) begin
        for (int p = 0; p < 2; p++)
          for (int c = 0; c < 64; c++) bk_v[p][c] = 1'b0;
      end
      m_last = granted;
    end
    for (int p = 0; p < 2; p++) bk_v[p][cyc % 64] = 1'b0;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_inputs();
    request    = '0;
    port_sel   = '0;
    writes_dst = '0;
    dst_flat   = '0;
    fu_busy_0  = 1'b0;
    fu_busy_1  = 1'b0;
    prmiss     = 1'b0;
    for (int i = 0; i < N; i++) lat_flat[i*LW +: LW] = LW'(1);
  endtask

  task automatic set_ent(input int i, input bit ps, input bit wd, input int dst, input int lat);
    port_sel[i]          = ps;
    writes_dst[i]        = wd;
    dst_flat[i*PW +: PW] = PW'(dst);
    lat_flat[i*LW +: LW] = LW'(lat);
  endtask

  task automatic idle(input int n);
    request = '0;
    prmiss  = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    step();
    step();
    checks++;
    if ({g0, g1, b1, b2} !== 24'h0) begin
      errors++;
      $display("FAIL reset_state: got %h want 000000", {g0, g1, b1, b2});
    end
    reset = 1'b0;
    for (int n = 0; n < 5; n++) begin
      step();
      checks++;
      if ({g0, g1, b1, b2} !== 24'h0) begin
        errors++;
        $display("FAIL idle_after_reset[%0d]: got %h want 000000", n, {g0, g1, b1, b2});
      end
    end
  endtask

  task automatic test_priority_mask();
    clear_inputs();
    set_ent(3, 1'b0, 1'b1, 12, 1);
    set_ent(5, 1'b0, 1'b1, 20, 1);
    request = 16'h0028;
    step();
    checks++;
    if ({g0, b1} !== {5'h13, 7'h4C}) begin
      errors++;
      $display("FAIL prio_first: got g0=%h b1=%h want g0=13 b1=4c", g0, b1);
    end
    step();
    checks++;
    if ({g0, b1} !== {5'h15, 7'h54}) begin
      errors++;
      $display("FAIL prio_masked_next: got g0=%h b1=%h want g0=15 b1=54", g0, b1);
    end
    request = '0;
    step();
    checks++;
    if ({g0, b1} !== 12'h0) begin
      errors++;
      $display("FAIL prio_drain: got g0=%h b1=%h want 0", g0, b1);
    end
    idle(4);
  endtask

  task automatic test_slot_collision();
    clear_inputs();
    set_ent(2, 1'b1, 1'b1, 9, 3);
    set_ent(4, 1'b1, 1'b1, 7, 2);
    request = 16'h0004;
    step();
    checks++;
    if (g1 !== 5'h12) begin
      errors++;
      $display("FAIL coll_grant2: got %h want 12", g1);
    end
    request = 16'h0010;
    step();
    checks++;
    if ({g1, b2} !== 12'h0) begin
      errors++;
      $display("FAIL coll_blocked: got g1=%h b2=%h want 0", g1, b2);
    end
    step();
    checks++;
    if ({g1, b2} !== {5'h14, 7'h49}) begin
      errors++;
      $display("FAIL coll_grant4: got g1=%h b2=%h want g1=14 b2=49", g1, b2);
    end
    request = '0;
    step();
    checks++;
    if ({g1, b2} !== {5'h00, 7'h47}) begin
      errors++;
      $display("FAIL coll_tag7: got g1=%h b2=%h want g1=00 b2=47", g1, b2);
    end
    step();
    checks++;
    if (b2 !== 7'h0) begin
      errors++;
      $display("FAIL coll_drain: got b2=%h want 0", b2);
    end
    idle(4);
  endtask

  task automatic test_fu_busy();
    clear_inputs();
    set_ent(1, 1'b0, 1'b1, 5, 1);
    set_ent(6, 1'b1, 1'b1, 40, 1);
    fu_busy_0 = 1'b1;
    request = 16'h0042;
    step();
    checks++;
    if ({g0, g1, b1, b2} !== {5'h00, 5'h16, 7'h00, 7'h68}) begin
      errors++;
      $display("FAIL busy_port1_only: got %h want %h", {g0, g1, b1, b2}, {5'h00, 5'h16, 7'h00, 7'h68});
    end
    request = 16'h0002;
    step();
    checks++;
    if (g0 !== 5'h0) begin
      errors++;
      $display("FAIL busy_hold: got g0=%h want 00", g0);
    end
    fu_busy_0 = 1'b0;
    step();
    checks++;
    if ({g0, b1} !== {5'h11, 7'h45}) begin
      errors++;
      $display("FAIL busy_release: got g0=%h b1=%h want g0=11 b1=45", g0, b1);
    end
    idle(4);
  endtask

  task automatic test_prmiss();
    clear_inputs();
    set_ent(0, 1'b0, 1'b1, 33, 4);
    request = 16'h0001;
    step();
    checks++;
    if (g0 !== 5'h10) begin
      errors++;
      $display("FAIL pm_grant: got g0=%h want 10", g0);
    end
    request = '0;
    step();
    checks++;
    if (b1 !== 7'h0) begin
      errors++;
      $display("FAIL pm_bcast_t2: got b1=%h want 0", b1);
    end
    prmiss  = 1'b1;
    request = 16'h0001;
    step();
    prmiss  = 1'b0;
    request = '0;
    checks++;
    if (g0 !== 5'h0) begin
      errors++;
      $display("FAIL pm_req_ignored: got g0=%h want 00", g0);
    end
    for (int n = 3; n <= 6; n++) begin
      checks++;
      if (b1 !== 7'h0) begin
        errors++;
        $display("FAIL pm_bcast_t%0d: got b1=%h want 0", n, b1);
      end
      step();
    end
    idle(3);
  endtask

  task automatic test_no_dst();
    clear_inputs();
    set_ent(7, 1'b0, 1'b0, 50, 1);
    request = 16'h0080;
    step();
    request = '0;
    checks++;
    if ({g0, b1} !== {5'h17, 7'h00}) begin
      errors++;
      $display("FAIL nodst: got g0=%h b1=%h want g0=17 b1=00", g0, b1);
    end
    step();
    checks++;
    if (b1 !== 7'h0) begin
      errors++;
      $display("FAIL nodst_later: got b1=%h want 0", b1);
    end
    idle(3);
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    set_ent(9, 1'b1, 1'b1, 21, 4);
    request = 16'h0200;
    step();
    request = '0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int n = 0; n < 5; n++) begin
      checks++;
      if ({g0, g1, b1, b2} !== 24'h0) begin
        errors++;
        $display("FAIL reset_mid[%0d]: got %h want 000000", n, {g0, g1, b1, b2});
      end
      step();
    end
  endtask

  task automatic test_random();
    bit         ev;
    bit [PW-1:0] et;
    for (int n = 0; n < 600; n++) begin
      checks++;
      if (g0 !== {m_gv[0], m_gi[0]}) begin
        errors++;
        $display("FAIL rand_g0 cyc=%0d: got %h want %h", cyc, g0, {m_gv[0], m_gi[0]});
      end
      checks++;
      if (g1 !== {m_gv[1], m_gi[1]}) begin
        errors++;
        $display("FAIL rand_g1 cyc=%0d: got %h want %h", cyc, g1, {m_gv[1], m_gi[1]});
      end
      ev = bk_v[0][cyc % 64];
      et = ev ? bk_tag[0][cyc % 64] : '0;
      checks++;
      if (b1 !== {ev, et}) begin
        errors++;
        $display("FAIL rand_b1 cyc=%0d: got %h want %h", cyc, b1, {ev, et});
      end
      ev = bk_v[1][cyc % 64];
      et = ev ? bk_tag[1][cyc % 64] : '0;
      checks++;
      if (b2 !== {ev, et}) begin
        errors++;
        $display("FAIL rand_b2 cyc=%0d: got %h want %h", cyc, b2, {ev, et});
      end
      request    = N'($urandom);
      port_sel   = N'($urandom);
      writes_dst = N'($urandom) | N'($urandom);
      for (int i = 0; i < N; i++) begin
        dst_flat[i*PW +: PW] = PW'($urandom_range(1, 63));
        lat_flat[i*LW +: LW] = LW'($urandom_range(1, ML));
      end
      fu_busy_0 = ($urandom_range(0, 3) == 0);
      fu_busy_1 = ($urandom_range(0, 3) == 0);
      prmiss    = ($urandom_range(0, 15) == 0);
      reset     = ($urandom_range(0, 99) == 0);
      step();
    end
    reset = 1'b0;
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_priority_mask();
    test_slot_collision();
    test_fu_busy();
    test_prmiss();
    test_no_dst();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/iq_select_broadcast.md
Name: iq_select_broadcast

Overview:
- Select-and-broadcast side of the issue queue wakeup protocol.
- Each cycle it picks at most one ready entry per execution port (2 ports) from the IQ request vector and returns registered grants to the IQ payload read.
- It schedules each granted entry's destination tag onto broadcast_tag1/broadcast_tag2 after that entry's execution latency; the IQ CAM compares these tags against its source tags.

Parameters:
IQ_ENT_NUM, 16, number of IQ entries
IQ_ENT_SEL, 4, log2(IQ_ENT_NUM)
PHY_REG_SEL, 6, physical register tag width
MAX_LATENCY, 4, largest FU latency in cycles (1..MAX_LATENCY)
LAT_W, 3, width of per-entry latency field

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
request  in  IQ_ENT_NUM  entry i ready (both R bits set, valid)
port_sel  in  IQ_ENT_NUM  entry i bound to port 0 (0) or port 1 (1)
writes_dst  in  IQ_ENT_NUM  entry i produces a register result
dst_flat  in  IQ_ENT_NUM*PHY_REG_SEL  entry i dst tag at bits [i*PHY_REG_SEL +: PHY_REG_SEL]
lat_flat  in  IQ_ENT_NUM*LAT_W  entry i latency at [i*LAT_W +: LAT_W]
fu_busy_0  in  1  port 0 cannot accept an issue this cycle
fu_busy_1  in  1  port 1 cannot accept an issue this cycle
prmiss  in  1  branch mispredict flush
grant_valid_0  out  1  port 0 issued an entry
grant_idx_0  out  IQ_ENT_SEL  issued entry index, port 0
grant_valid_1  out  1  port 1 issued an entry
grant_idx_1  out  IQ_ENT_SEL  issued entry index, port 1
bcast_valid_1  out  1  broadcast_tag1 is live
broadcast_tag1  out  PHY_REG_SEL  port 0 result tag
bcast_valid_2  out  1  broadcast_tag2 is live
broadcast_tag2  out  PHY_REG_SEL  port 1 result tag

Behaviour:
- Reset value of all outputs: 0. Reset also clears all schedule slots and the grant mask.
- Idle broadcast tag is 0. Physical tag 0 is the hardwired-zero register and is never a pending source, so driving 0 cannot falsely wake an entry.
- Candidate on port p: request[i] && port_sel[i]==p && !mask[i] && slot_free(i).
- Candidate selection: fixed priority, lowest index wins.
- No grant on port p in a cycle where fu_busy_p=1.
- Mask: mask[i]=1 for exactly the cycle after entry i was granted. This covers the IQ's one-cycle lag in clearing valid and prevents a double issue.
- Schedule per port: slots s[0..MAX_LATENCY-1], each {valid, tag}.
  - Every cycle: s[k] <= s[k+1]; the top slot is loaded with invalid.
  - s[0] drives bcast_valid/broadcast_tag for that port.
- Grant at cycle t with latency L and writes_dst=1: s[L-1] <= {1, dst} at the end of cycle t.
  - Grant outputs are registered and visible in cycle t+1.
  - The broadcast is visible in cycle t+L. L=1 broadcasts in the same cycle as the grant is visible, which allows back-to-back dependent issue.
- slot_free(i): writes_dst[i]==0, or L==MAX_LATENCY, or the current s[L] of that port is invalid. This prevents two results colliding on one broadcast cycle.
  - An entry blocked by slot_free is skipped; the next lowest-index candidate is considered in the same cycle.
- writes_dst=0: the entry is granted but no slot is written.
- Latency 0 or latency > MAX_LATENCY is illegal; the IQ never presents it. Verification asserts against it.
- Both ports grant independently in the same cycle. An entry is never granted on both ports, because port_sel is exclusive.
- prmiss: at the next edge, clear all slots, both grant_valid outputs, and the mask. Requests sampled in the prmiss cycle are ignored.
- Reset mid-operation: identical to prmiss and additionally zeroes all tag and index outputs.
- grant_idx_p and broadcast_tag hold 0 whenever the corresponding valid is 0.

Test Plan:
- Reset, then request=0 -> all outputs 0 for 5 cycles; broadcast tags stay 0.
- Entries 3 and 5 on port 0 (dst 12, 20; L=1), request at t -> t+1: grant_idx_0=3, bcast tag1=12. Entry 3 is masked in t+1 while request still high, so t+2: grant_idx_0=5, tag1=20.
- Entry 2 on port 1 (L=3, dst 9) granted at t; entry 4 on port 1 (L=2, dst 7) requests at t+1 -> entry 4 is blocked (s[2] occupied after shift) and granted at t+2; tag2=9 at t+3, tag2=7 at t+4, no cycle carries two tags.
- Entries 1 (port 0) and 6 (port 1) request, fu_busy_0=1 -> only grant_valid_1=1, grant_idx_1=6; entry 1 is granted the first cycle fu_busy_0 drops.
- Entry 0 granted with L=4 (dst 33), prmiss asserted at t+2 -> bcast_valid_1 stays 0 through t+6.
- Entry 7 with writes_dst=0, L=1 -> granted; bcast_valid remains 0.
